// File: rtl/fft_pkg.sv
// Shared constants, loader FSM encoding and the address bit-reversal helper
// for the FFT sample loader.
package fft_pkg;
  localparam int FFT_DATA_W      = 16;
  localparam int FFT_ADDR_W      = 9;
  localparam int FFT_NUM_SAMPLES = 1 << FFT_ADDR_W;

  typedef enum logic [1:0] {LOAD, PRIME, STREAM} loader_state_t;

  function automatic logic [FFT_ADDR_W-1:0] bitrev(input logic [FFT_ADDR_W-1:0] a);
    logic [FFT_ADDR_W-1:0] r;
    for (int i = 0; i < FFT_ADDR_W; i++) r[i] = a[FFT_ADDR_W-1-i];
    return r;
  endfunction
endpackage

// File: rtl/fft_sample_ram.sv
// Simple dual-port sample RAM: one write port, one registered read port.
// Read data holds its value while re is low, so it doubles as a read-ahead buffer.
module fft_sample_ram #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 9,
  parameter int DEPTH  = 512
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic              re,
  input  logic [ADDR_W-1:0] raddr,
  output logic [DATA_W-1:0] rdata
);
  logic [DATA_W-1:0] mem [DEPTH];
  logic [DATA_W-1:0] rdata_q;

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    if (re) rdata_q <= mem[raddr];
  end

  assign rdata = rdata_q;
endmodule

// File: rtl/fft_sample_loader.sv
// Loads bus-paced sample writes into RAM at bit-reversed addresses, then streams
// the frame in RAM order to the FFT core over valid/ready.
module fft_sample_loader
  import fft_pkg::*;
#(
  parameter int DATA_W      = FFT_DATA_W,
  parameter int ADDR_W      = FFT_ADDR_W,
  parameter int NUM_SAMPLES = FFT_NUM_SAMPLES
) (
  input  logic              clk,
  input  logic              n_rst,
  input  logic              sWriteEn,
  input  logic [ADDR_W-1:0] wAddress,
  input  logic [DATA_W-1:0] fft_init_data,
  input  logic              fft_start,
  input  logic              out_ready,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_data,
  output logic [ADDR_W-1:0] out_index,
  output logic              out_last,
  output logic              busy,
  output logic [ADDR_W:0]   load_count,
  output logic              overrun
);
  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(NUM_SAMPLES - 1);
  localparam logic [ADDR_W:0]   CNT_MAX  = (ADDR_W+1)'(NUM_SAMPLES);

  loader_state_t     state_q, state_d;
  logic              prime2_q, prime2_d;
  logic [ADDR_W-1:0] rd_addr_q, rd_addr_d;
  logic              out_valid_q, out_valid_d;
  logic [DATA_W-1:0] out_data_q, out_data_d;
  logic [ADDR_W-1:0] out_index_q, out_index_d;
  logic              out_last_q, out_last_d;
  logic [ADDR_W:0]   load_count_q, load_count_d;
  logic              overrun_q, overrun_d;

  logic              ram_we, ram_re;
  logic [ADDR_W-1:0] waddr_rev;
  logic [DATA_W-1:0] ram_rdata;

  for (genvar i = 0; i < ADDR_W; i++) begin : g_rev
    assign waddr_rev[i] = wAddress[ADDR_W-1-i];
  end

  assign ram_we = (state_q == LOAD) && (sWriteEn == 1'b1);

  fft_sample_ram #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .DEPTH(NUM_SAMPLES)) u_ram (
    .clk   (clk),
    .we    (ram_we),
    .waddr (waddr_rev),
    .wdata (fft_init_data),
    .re    (ram_re),
    .raddr (rd_addr_q),
    .rdata (ram_rdata)
  );

  always_comb begin
    state_d      = state_q;
    prime2_d     = prime2_q;
    rd_addr_d    = rd_addr_q;
    out_valid_d  = out_valid_q;
    out_data_d   = out_data_q;
    out_index_d  = out_index_q;
    out_last_d   = out_last_q;
    load_count_d = load_count_q;
    overrun_d    = overrun_q;
    ram_re       = 1'b0;

    case (state_q)
      LOAD: begin
        if (ram_we && load_count_q != CNT_MAX) load_count_d = load_count_q + 1'b1;
        if (fft_start == 1'b1) begin
          state_d      = PRIME;
          prime2_d     = 1'b0;
          rd_addr_d    = '0;
          load_count_d = '0;
          overrun_d    = 1'b0;
        end
      end
      PRIME: begin
        // First cycle fetches RAM[0]; second moves it to the output and fetches RAM[1].
        ram_re    = 1'b1;
        rd_addr_d = rd_addr_q + 1'b1;
        prime2_d  = 1'b1;
        if (prime2_q) begin
          state_d     = STREAM;
          prime2_d    = 1'b0;
          out_valid_d = 1'b1;
          out_data_d  = ram_rdata;
          out_index_d = '0;
          out_last_d  = (LAST_IDX == '0);
        end
      end
      STREAM: begin
        if (out_valid_q && out_ready) begin
          if (out_last_q) begin
            state_d     = LOAD;
            out_valid_d = 1'b0;
            out_index_d = '0;
            out_last_d  = 1'b0;
          end else begin
            // ram_rdata already holds the next sample; refill it with the one after.
            ram_re      = 1'b1;
            rd_addr_d   = rd_addr_q + 1'b1;
            out_data_d  = ram_rdata;
            out_index_d = out_index_q + 1'b1;
            out_last_d  = (out_index_q + 1'b1 == LAST_IDX);
          end
        end
      end
      default: state_d = LOAD;
    endcase

    if (state_q != LOAD && sWriteEn == 1'b1) overrun_d = 1'b1;
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q      <= LOAD;
      prime2_q     <= 1'b0;
      rd_addr_q    <= '0;
      out_valid_q  <= 1'b0;
      out_data_q   <= '0;
      out_index_q  <= '0;
      out_last_q   <= 1'b0;
      load_count_q <= '0;
      overrun_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      prime2_q     <= prime2_d;
      rd_addr_q    <= rd_addr_d;
      out_valid_q  <= out_valid_d;
      out_data_q   <= out_data_d;
      out_index_q  <= out_index_d;
      out_last_q   <= out_last_d;
      load_count_q <= load_count_d;
      overrun_q    <= overrun_d;
    end
  end

  assign out_valid  = out_valid_q;
  assign out_data   = out_data_q;
  assign out_index  = out_index_q;
  assign out_last   = out_last_q;
  assign busy       = (state_q != LOAD);
  assign load_count = load_count_q;
  assign overrun    = overrun_q;
endmodule

// File: tb/tb_fft_sample_loader.sv
// Directed bench for fft_sample_loader: load, stream, stalls, overrun, reset, saturation.
module tb_fft_sample_loader;
  localparam int AW = 9;
  localparam int DW = 16;
  localparam int N  = 512;

  logic          clk = 1'b0, n_rst = 1'b0;
  logic          sWriteEn = 1'b0, fft_start = 1'b0, out_ready = 1'b0;
  logic [AW-1:0] wAddress = '0;
  logic [DW-1:0] fft_init_data = '0;
  logic          out_valid, out_last, busy, overrun;
  logic [DW-1:0] out_data;
  logic [AW-1:0] out_index;
  logic [AW:0]   load_count;
  int checks = 0, failures = 0;

  always #5 clk = ~clk;

  fft_sample_loader dut (
    .clk(clk), .n_rst(n_rst), .sWriteEn(sWriteEn), .wAddress(wAddress),
    .fft_init_data(fft_init_data), .fft_start(fft_start), .out_ready(out_ready),
    .out_valid(out_valid), .out_data(out_data), .out_index(out_index),
    .out_last(out_last), .busy(busy), .load_count(load_count), .overrun(overrun)
  );

  function automatic logic [AW-1:0] rev(input logic [AW-1:0] a);
    logic [AW-1:0] r;
    for (int i = 0; i < AW; i++) r[AW-1-i] = a[i];
    return r;
  endfunction

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic write(input logic [AW-1:0] a, input logic [DW-1:0] d);
    sWriteEn = 1'b1; wAddress = a; fft_init_data = d;
    tick();
    sWriteEn = 1'b0;
  endtask

  task automatic load_frame(input logic [DW-1:0] base);
    for (int k = 0; k < N; k++) write(AW'(k), base + DW'(k));
  endtask

  task automatic pulse_start();
    fft_start = 1'b1;
    tick();
    fft_start = 1'b0;
  endtask

  task automatic wait_valid(output bit ok);
    ok = 1'b0;
    for (int c = 0; c < 10 && !ok; c++) begin
      if (out_valid) ok = 1'b1;
      else tick();
    end
  endtask

  task automatic test_reset();
    n_rst = 1'b0;
    tick(); tick();
    checks++;
    if ({out_valid, out_last, busy, overrun, out_data, out_index, load_count} !== '0) begin
      failures++;
      $display("FAIL reset_values: got v=%b l=%b b=%b o=%b d=%h i=%0d c=%0d, expected all zero",
               out_valid, out_last, busy, overrun, out_data, out_index, load_count);
    end
    n_rst = 1'b1;
    tick();
  endtask

  task automatic test_full_frame();
    load_frame(16'h0000);
    checks++;
    if (load_count !== 10'd512 || busy !== 1'b0) begin
      failures++;
      $display("FAIL load_count_full: got count=%0d busy=%b, expected 512/0", load_count, busy);
    end
    out_ready = 1'b1;
    pulse_start();
    checks++;
    if (busy !== 1'b1 || out_valid !== 1'b0) begin
      failures++;
      $display("FAIL start_edge: got busy=%b valid=%b, expected 1/0", busy, out_valid);
    end
    tick();
    checks++;
    if (out_valid !== 1'b0) begin
      failures++;
      $display("FAIL start_plus1: got valid=%b, expected 0", out_valid);
    end
    tick();
    checks++;
    if (out_valid !== 1'b1) begin
      failures++;
      $display("FAIL start_plus2: got valid=%b, expected 1", out_valid);
    end
    for (int i = 0; i < N; i++) begin
      checks++;
      if (out_valid !== 1'b1 || out_index !== AW'(i) || out_data !== DW'(rev(AW'(i))) ||
          out_last !== (i == N-1)) begin
        failures++;
        $display("FAIL beat_%0d: got v=%b i=%0d d=%0d l=%b, expected 1/%0d/%0d/%b",
                 i, out_valid, out_index, out_data, out_last, i, rev(AW'(i)), (i == N-1));
      end
      tick();
    end
    checks++;
    if (out_valid !== 1'b0 || busy !== 1'b0 || out_index !== '0) begin
      failures++;
      $display("FAIL frame_end: got v=%b busy=%b i=%0d, expected 0/0/0", out_valid, busy, out_index);
    end
  endtask

  task automatic test_stalls();
    int exp_i = 0, cyc = 0;
    bit v;
    out_ready = 1'b0;
    pulse_start();
    while (exp_i < N && cyc < 6000) begin
      if (out_valid) begin
        checks++;
        if (out_index !== AW'(exp_i) || out_data !== DW'(rev(AW'(exp_i))) ||
            out_last !== (exp_i == N-1)) begin
          failures++;
          $display("FAIL stall_beat_%0d: got i=%0d d=%0d l=%b, expected %0d/%0d/%b",
                   exp_i, out_index, out_data, out_last, exp_i, rev(AW'(exp_i)), (exp_i == N-1));
        end
      end
      out_ready = (cyc < 200) ? cyc[0] : 1'($urandom_range(0, 1));
      v = out_valid;
      tick();
      if (v && out_ready) exp_i++;
      cyc++;
    end
    checks++;
    if (exp_i != N || out_valid !== 1'b0 || busy !== 1'b0) begin
      failures++;
      $display("FAIL stall_total: got beats=%0d v=%b busy=%b, expected %0d/0/0", exp_i, out_valid, busy, N);
    end
  endtask

  task automatic test_overrun();
    bit ok;
    int bad = 0;
    out_ready = 1'b0;
    pulse_start();
    wait_valid(ok);
    checks++;
    if (!ok) begin failures++; $display("FAIL ovr_valid_timeout: got no valid, expected valid"); end
    write(AW'(0), 16'hDEAD);
    checks++;
    if (overrun !== 1'b1 || out_index !== '0 || out_data !== '0) begin
      failures++;
      $display("FAIL ovr_set: got ovr=%b i=%0d d=%h, expected 1/0/0000", overrun, out_index, out_data);
    end
    out_ready = 1'b1;
    for (int i = 0; i < N; i++) begin
      if (out_valid !== 1'b1 || out_index !== AW'(i) || out_data !== DW'(rev(AW'(i)))) bad++;
      tick();
    end
    checks++;
    if (bad != 0 || busy !== 1'b0 || overrun !== 1'b1) begin
      failures++;
      $display("FAIL ovr_stream: got bad=%0d busy=%b ovr=%b, expected 0/0/1", bad, busy, overrun);
    end
    pulse_start();
    checks++;
    if (overrun !== 1'b0) begin failures++; $display("FAIL ovr_clear: got %b, expected 0", overrun); end
    for (int c = 0; c < 600 && busy; c++) tick();
  endtask

  task automatic test_same_cycle();
    bit ok;
    logic [DW-1:0] got = '0;
    sWriteEn = 1'b1; wAddress = AW'(5); fft_init_data = 16'hA5A5; fft_start = 1'b1;
    tick();
    sWriteEn = 1'b0; fft_start = 1'b0;
    checks++;
    if (load_count !== '0 || busy !== 1'b1) begin
      failures++;
      $display("FAIL same_start: got count=%0d busy=%b, expected 0/1", load_count, busy);
    end
    out_ready = 1'b1;
    wait_valid(ok);
    for (int i = 0; i < N; i++) begin
      if (out_index == AW'(320)) got = out_data;
      tick();
    end
    checks++;
    if (!ok || got !== 16'hA5A5) begin
      failures++;
      $display("FAIL same_cycle_write: got %h at index 320, expected a5a5", got);
    end
  endtask

  task automatic test_reset_midstream();
    bit ok;
    int bad = 0;
    out_ready = 1'b1;
    pulse_start();
    wait_valid(ok);
    for (int i = 0; i < 100; i++) tick();
    #2 n_rst = 1'b0;
    #1;
    checks++;
    if ({out_valid, out_last, busy, overrun, out_data, out_index, load_count} !== '0 || !ok) begin
      failures++;
      $display("FAIL reset_mid: got v=%b i=%0d d=%h busy=%b, expected all zero",
               out_valid, out_index, out_data, busy);
    end
    tick();
    n_rst = 1'b1;
    tick();
    checks++;
    if (busy !== 1'b0 || out_valid !== 1'b0) begin
      failures++;
      $display("FAIL reset_release: got busy=%b v=%b, expected 0/0", busy, out_valid);
    end
    load_frame(16'h1000);
    checks++;
    if (load_count !== 10'd512) begin
      failures++;
      $display("FAIL reload_count: got %0d, expected 512", load_count);
    end
    pulse_start();
    wait_valid(ok);
    for (int i = 0; i < N; i++) begin
      if (out_valid !== 1'b1 || out_index !== AW'(i) || out_data !== 16'h1000 + DW'(rev(AW'(i)))) bad++;
      tick();
    end
    checks++;
    if (!ok || bad != 0) begin
      failures++;
      $display("FAIL reload_stream: got bad=%0d ok=%b, expected 0/1", bad, ok);
    end
  endtask

  task automatic test_saturate();
    bit ok;
    int bad = 0;
    logic [AW-1:0] a;
    logic [DW-1:0] e;
    wAddress = AW'(7); fft_init_data = 16'hFFFF;
    sWriteEn = 1'bz; tick(); tick(); tick();
    sWriteEn = 1'b0; tick(); tick();
    checks++;
    if (load_count !== '0) begin
      failures++;
      $display("FAIL nowrite_count: got %0d, expected 0", load_count);
    end
    for (int k = 0; k < 600; k++) write(AW'(k), DW'(k));
    checks++;
    if (load_count !== 10'd512) begin
      failures++;
      $display("FAIL saturate: got %0d, expected 512", load_count);
    end
    wAddress = AW'(7); fft_init_data = 16'hFFFF;
    sWriteEn = 1'bz; tick(); tick();
    sWriteEn = 1'b0;
    out_ready = 1'b1;
    pulse_start();
    wait_valid(ok);
    for (int i = 0; i < N; i++) begin
      a = rev(AW'(i));
      e = (a < 88) ? DW'(a) + 16'd512 : DW'(a);
      if (out_valid !== 1'b1 || out_index !== AW'(i) || out_data !== e) bad++;
      tick();
    end
    checks++;
    if (!ok || bad != 0) begin
      failures++;
      $display("FAIL saturate_stream: got bad=%0d ok=%b, expected 0/1", bad, ok);
    end
  endtask

  initial begin
    test_reset();
    test_full_frame();
    test_stalls();
    test_overrun();
    test_same_cycle();
    test_reset_midstream();
    test_saturate();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
